// File: rtl/cfg_bridge_pkg.sv
// cfg_bridge_pkg: shared types and field positions for the
// CQ/CC to cfg_mgmt bridge.
package cfg_bridge_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   localparam logic [2:0] ST_SC = 3'b000;
   localparam logic [2:0] ST_UR = 3'b001;
   localparam logic [2:0] ST_CA = 3'b100;

   localparam logic [3:0] REQ_CFG_RD0 = 4'b1000;
   localparam logic [3:0] REQ_CFG_RD1 = 4'b1001;
   localparam logic [3:0] REQ_CFG_WR0 = 4'b1010;
   localparam logic [3:0] REQ_CFG_WR1 = 4'b1011;

   localparam int CQ_ADDR_LSB = 2;
   localparam int CQ_TYPE_LSB = 75;
   localparam int CQ_RID_LSB  = 80;
   localparam int CQ_TAG_LSB  = 96;
   localparam int CQ_FN_LSB   = 104;
   localparam int CQ_WD_LSB   = 128;

   localparam int CC_LA_LSB   = 0;
   localparam int CC_BC_LSB   = 16;
   localparam int CC_DW_LSB   = 32;
   localparam int CC_ST_LSB   = 43;
   localparam int CC_RID_LSB  = 48;
   localparam int CC_TAG_LSB  = 64;
   localparam int CC_FN_LSB   = 72;
   localparam int CC_DATA_LSB = 96;

   function automatic logic is_cfg_req(input logic [3:0] t);
      return t[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/cc_desc_builder.sv
// cc_desc_builder: packs the CC completion descriptor and
// optional read dword from the captured request fields.
module cc_desc_builder
   import cfg_bridge_pkg::*;
#(
   parameter int W  = 512,
   parameter int KW = 16
) (
   input  logic          valid,
   input  logic [4:0]    reg_lo,
   input  logic [2:0]    status,
   input  logic          has_data,
   input  logic [15:0]   req_id,
   input  logic [7:0]    tag,
   input  logic [7:0]    func,
   input  logic [31:0]   rd_data,
   output logic [W-1:0]  tdata,
   output logic [KW-1:0] tkeep
);

   always_comb begin
      tdata = '0;
      tkeep = '0;
      if (valid) begin
         tdata[CC_LA_LSB +: 7]   = {reg_lo, 2'b00};
         tdata[CC_BC_LSB +: 13]  = 13'd4;
         tdata[CC_DW_LSB +: 11]  = {10'd0, has_data};
         tdata[CC_ST_LSB +: 3]   = status;
         tdata[CC_RID_LSB +: 16] = req_id;
         tdata[CC_TAG_LSB +: 8]  = tag;
         tdata[CC_FN_LSB +: 8]   = func;
         if (has_data) begin
            tdata[CC_DATA_LSB +: 32] = rd_data;
         end
         tkeep[4:0] = has_data ? 5'h1F : 5'h0F;
      end
   end

endmodule

// File: rtl/cqt1_cfg_mgmt_bridge.sv
// cqt1_cfg_mgmt_bridge: CQ config request -> cfg_mgmt -> CC.
// Define CQT1_CFG_TIMEOUT_EN to enable the cfg_mgmt watchdog.
module cqt1_cfg_mgmt_bridge
   import cfg_bridge_pkg::*;
#(
   parameter int         DSP_IF_WIDTH       = 512,
   parameter int         DSP_TKEEP_WIDTH    = 16,
   parameter int         DSP_CQ_TUSER_WIDTH = 231,
   parameter int         DSP_CC_TUSER_WIDTH = 81,
   parameter int         NUM_FUNCS          = 1,
   parameter logic [1:0] SELECT_VALUE       = 2'b01,
   parameter int         TIMEOUT_CYCLES     = 1024
) (
   input  logic                          user_clk,
   input  logic                          user_reset_n,
   input  logic [DSP_IF_WIDTH-1:0]       dsp_m_axis_cq_tdata,
   input  logic [DSP_TKEEP_WIDTH-1:0]    dsp_m_axis_cq_tkeep,
   input  logic                          dsp_m_axis_cq_tlast,
   input  logic [DSP_CQ_TUSER_WIDTH-1:0] dsp_m_axis_cq_tuser,
   input  logic                          dsp_m_axis_cq_tvalid,
   output logic                          dsp_m_axis_cq_tready,
   input  logic [1:0]                    select,
   output logic [DSP_IF_WIDTH-1:0]       dsp_s_axis_cc_tdata,
   output logic [DSP_TKEEP_WIDTH-1:0]    dsp_s_axis_cc_tkeep,
   output logic [DSP_CC_TUSER_WIDTH-1:0] dsp_s_axis_cc_tuser,
   output logic                          dsp_s_axis_cc_tlast,
   output logic                          dsp_s_axis_cc_tvalid,
   input  logic                          dsp_s_axis_cc_tready,
   output logic [9:0]                    cfg_mgmt_addr,
   output logic [7:0]                    cfg_mgmt_function_number,
   output logic                          cfg_mgmt_write,
   output logic                          cfg_mgmt_read,
   output logic                          cfg_mgmt_debug_access,
   output logic [31:0]                   cfg_mgmt_write_data,
   output logic [3:0]                    cfg_mgmt_byte_enable,
   input  logic [31:0]                   cfg_mgmt_read_data,
   input  logic                          cfg_mgmt_read_write_done
);

   state_t      state, nxt;
   logic        cq_acc, is_req, fn_ok, in_acc, tmo_hit, done;
   logic [3:0]  cq_type;
   logic [7:0]  cq_fn;
   logic [9:0]  reg_q;
   logic [7:0]  fn_q, tag_q;
   logic [3:0]  be_q;
   logic [31:0] wd_q, rd_q;
   logic [15:0] rid_q;
   logic [2:0]  st_q;
   logic        wr_q, unused_cq;

   assign cq_acc  = dsp_m_axis_cq_tvalid & dsp_m_axis_cq_tready;
   assign cq_type = dsp_m_axis_cq_tdata[CQ_TYPE_LSB +: 4];
   assign cq_fn   = dsp_m_axis_cq_tdata[CQ_FN_LSB +: 8];
   assign is_req  = is_cfg_req(cq_type) && (select == SELECT_VALUE);
   assign fn_ok   = int'({24'd0, cq_fn}) < NUM_FUNCS;
   assign in_acc  = (state == S_ACCESS);
   assign done    = in_acc & cfg_mgmt_read_write_done;
   assign unused_cq = ^{dsp_m_axis_cq_tkeep, dsp_m_axis_cq_tuser,
                        dsp_m_axis_cq_tdata};

`ifdef CQT1_CFG_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] tmo_cnt;

   assign tmo_hit = in_acc & ~cfg_mgmt_read_write_done &
                    (tmo_cnt == TMO_LAST);

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         tmo_cnt <= '0;
      end else if (in_acc && !done && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + CW'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   localparam int unused_tmo = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // A first beat without tlast always drains, request or not.
   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: begin
            if (cq_acc) begin
               if (!dsp_m_axis_cq_tlast) begin
                  nxt = S_DRAIN;
               end else if (is_req) begin
                  nxt = fn_ok ? S_ACCESS : S_RESP;
               end
            end
         end
         S_ACCESS: begin
            if (done || tmo_hit) begin
               nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (dsp_s_axis_cc_tready) begin
               nxt = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (cq_acc && dsp_m_axis_cq_tlast) begin
               nxt = S_IDLE;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         dsp_m_axis_cq_tready <= 1'b0;
         reg_q <= '0;
         fn_q  <= '0;
         be_q  <= '0;
         wd_q  <= '0;
         wr_q  <= 1'b0;
         rid_q <= '0;
         tag_q <= '0;
         st_q  <= ST_SC;
         rd_q  <= '0;
      end else begin
         dsp_m_axis_cq_tready <= (nxt == S_IDLE) || (nxt == S_DRAIN);
         if ((state == S_IDLE) && cq_acc && dsp_m_axis_cq_tlast && is_req) begin
            reg_q <= dsp_m_axis_cq_tdata[CQ_ADDR_LSB +: 10];
            fn_q  <= cq_fn;
            be_q  <= dsp_m_axis_cq_tuser[3:0];
            wd_q  <= dsp_m_axis_cq_tdata[CQ_WD_LSB +: 32];
            wr_q  <= cq_type[1];
            rid_q <= dsp_m_axis_cq_tdata[CQ_RID_LSB +: 16];
            tag_q <= dsp_m_axis_cq_tdata[CQ_TAG_LSB +: 8];
            st_q  <= fn_ok ? ST_SC : ST_UR;
         end
         if (done) begin
            rd_q <= cfg_mgmt_read_data;
         end
         if (tmo_hit) begin
            st_q <= ST_CA;
         end
      end
   end

   assign cfg_mgmt_addr            = reg_q;
   assign cfg_mgmt_function_number = fn_q;
   assign cfg_mgmt_byte_enable     = be_q;
   assign cfg_mgmt_write_data      = wd_q;
   assign cfg_mgmt_read            = in_acc & ~wr_q;
   assign cfg_mgmt_write           = in_acc & wr_q;
   assign cfg_mgmt_debug_access    = 1'b0;

   assign dsp_s_axis_cc_tvalid = (state == S_RESP);
   assign dsp_s_axis_cc_tlast  = (state == S_RESP);
   assign dsp_s_axis_cc_tuser  = '0;

   cc_desc_builder #(
      .W  (DSP_IF_WIDTH),
      .KW (DSP_TKEEP_WIDTH)
   ) u_cc_desc (
      .valid    (state == S_RESP),
      .reg_lo   (reg_q[4:0]),
      .status   (st_q),
      .has_data (~wr_q && (st_q == ST_SC)),
      .req_id   (rid_q),
      .tag      (tag_q),
      .func     (fn_q),
      .rd_data  (rd_q),
      .tdata    (dsp_s_axis_cc_tdata),
      .tkeep    (dsp_s_axis_cc_tkeep)
   );

endmodule

// File: tb/tb_cqt1_cfg_mgmt_bridge.sv
// tb_cqt1_cfg_mgmt_bridge: directed vectors for the cfg bridge.
// Timeout sequence is built when CQT1_CFG_TIMEOUT_EN is defined.
module tb_cqt1_cfg_mgmt_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [511:0] cq_tdata;
   logic [15:0]  cq_tkeep;
   logic         cq_tlast, cq_tvalid, cq_tready;
   logic [230:0] cq_tuser;
   logic [1:0]   sel;
   logic [511:0] cc_tdata;
   logic [15:0]  cc_tkeep;
   logic [80:0]  cc_tuser;
   logic         cc_tlast, cc_tvalid, cc_tready;
   logic [9:0]   m_addr;
   logic [7:0]   m_fn;
   logic         m_wr, m_rd, m_dbg, m_done;
   logic [31:0]  m_wd, m_rdata;
   logic [3:0]   m_be;

   int checks = 0;
   int errors = 0;

   cqt1_cfg_mgmt_bridge #(.TIMEOUT_CYCLES(16)) dut (
      .user_clk                 (clk),
      .user_reset_n             (rst_n),
      .dsp_m_axis_cq_tdata      (cq_tdata),
      .dsp_m_axis_cq_tkeep      (cq_tkeep),
      .dsp_m_axis_cq_tlast      (cq_tlast),
      .dsp_m_axis_cq_tuser      (cq_tuser),
      .dsp_m_axis_cq_tvalid     (cq_tvalid),
      .dsp_m_axis_cq_tready     (cq_tready),
      .select                   (sel),
      .dsp_s_axis_cc_tdata      (cc_tdata),
      .dsp_s_axis_cc_tkeep      (cc_tkeep),
      .dsp_s_axis_cc_tuser      (cc_tuser),
      .dsp_s_axis_cc_tlast      (cc_tlast),
      .dsp_s_axis_cc_tvalid     (cc_tvalid),
      .dsp_s_axis_cc_tready     (cc_tready),
      .cfg_mgmt_addr            (m_addr),
      .cfg_mgmt_function_number (m_fn),
      .cfg_mgmt_write           (m_wr),
      .cfg_mgmt_read            (m_rd),
      .cfg_mgmt_debug_access    (m_dbg),
      .cfg_mgmt_write_data      (m_wd),
      .cfg_mgmt_byte_enable     (m_be),
      .cfg_mgmt_read_data       (m_rdata),
      .cfg_mgmt_read_write_done (m_done)
   );

   typedef struct {
      logic [3:0]  typ;
      logic [7:0]  fn;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [15:0] rid;
      logic [7:0]  tag;
      int          dly;
      logic [31:0] rdata;
      logic        acc;
      logic        rd;
      logic        wr;
      logic [2:0]  st;
      logic [10:0] dw;
      logic [15:0] keep;
      logic [6:0]  la;
   } vec_t;

   vec_t vt[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] mk_cq(
      input logic [3:0] t, input logic [7:0] fn, input logic [9:0] a,
      input logic [15:0] rid, input logic [7:0] tg, input logic [31:0] wd);
      logic [511:0] d;
      d = '0;
      d[11:2]    = a;
      d[78:75]   = t;
      d[95:80]   = rid;
      d[103:96]  = tg;
      d[111:104] = fn;
      d[159:128] = wd;
      return d;
   endfunction

   task automatic send_beat(input logic [511:0] d, input logic [3:0] be,
                            input logic last);
      int n;
      n = 0;
      while (!cq_tready && n < 20) begin
         tick();
         n++;
      end
      chk("cq_tready_wait", 32'(cq_tready), 32'd1);
      cq_tdata  = d;
      cq_tuser  = {227'd0, be};
      cq_tlast  = last;
      cq_tvalid = 1'b1;
      tick();
      cq_tvalid = 1'b0;
      cq_tlast  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      send_beat(mk_cq(v.typ, v.fn, v.addr, v.rid, v.tag, v.wdata), v.be, 1'b1);
      if (v.acc) begin
         chk("mgmt_rd", 32'(m_rd), 32'(v.rd));
         chk("mgmt_wr", 32'(m_wr), 32'(v.wr));
         chk("mgmt_addr", 32'(m_addr), 32'(v.addr));
         chk("mgmt_fn", 32'(m_fn), 32'(v.fn));
         chk("mgmt_be", 32'(m_be), 32'(v.be));
         chk("mgmt_dbg", 32'(m_dbg), 32'd0);
         chk("cc_early", 32'(cc_tvalid), 32'd0);
         if (v.wr) chk("mgmt_wdata", m_wd, v.wdata);
         for (int i = 1; i < v.dly; i++) tick();
         chk("mgmt_held", 32'(m_rd | m_wr), 32'd1);
         m_rdata = v.rdata;
         m_done  = 1'b1;
         tick();
         m_done  = 1'b0;
         m_rdata = '0;
         chk("mgmt_release", 32'(m_rd | m_wr), 32'd0);
      end else begin
         chk("no_access", 32'(m_rd | m_wr), 32'd0);
      end
      chk("cc_valid", 32'(cc_tvalid), 32'd1);
      chk("cc_last", 32'(cc_tlast), 32'd1);
      chk("cc_user", 32'(|cc_tuser), 32'd0);
      chk("cc_la", 32'(cc_tdata[6:0]), 32'(v.la));
      chk("cc_bc", 32'(cc_tdata[28:16]), 32'd4);
      chk("cc_dw", 32'(cc_tdata[42:32]), 32'(v.dw));
      chk("cc_st", 32'(cc_tdata[45:43]), 32'(v.st));
      chk("cc_rid", 32'(cc_tdata[63:48]), 32'(v.rid));
      chk("cc_tag", 32'(cc_tdata[71:64]), 32'(v.tag));
      chk("cc_fn", 32'(cc_tdata[79:72]), 32'(v.fn));
      chk("cc_keep", 32'(cc_tkeep), 32'(v.keep));
      if (v.rd && v.st == 3'd0) chk("cc_data", cc_tdata[127:96], v.rdata);
      cc_tready = 1'b1;
      tick();
      cc_tready = 1'b0;
      chk("cc_done", 32'(cc_tvalid), 32'd0);
      chk("cq_rdy_after", 32'(cq_tready), 32'd1);
   endtask

   initial begin
      int n;
      vt[0] = '{4'b1000, 8'd0, 10'h004, 32'h0, 4'hF, 16'h0100, 8'h11, 3,
                32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 3'd0, 11'd1, 16'h001F, 7'h10};
      vt[1] = '{4'b1010, 8'd0, 10'h013, 32'h12345678, 4'h3, 16'h0203, 8'h22,
                2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 3'd0, 11'd0, 16'h000F, 7'h4C};
      vt[2] = '{4'b1001, 8'd0, 10'h3FF, 32'h0, 4'hF, 16'h0A0B, 8'h33, 1,
                32'hA5A55A5A, 1'b1, 1'b1, 1'b0, 3'd0, 11'd1, 16'h001F, 7'h7C};
      vt[3] = '{4'b1000, 8'd2, 10'h008, 32'h0, 4'hF, 16'h1111, 8'h44, 0,
                32'h0, 1'b0, 1'b1, 1'b0, 3'd1, 11'd0, 16'h000F, 7'h20};
      vt[4] = '{4'b1011, 8'd1, 10'h021, 32'h55AA55AA, 4'hF, 16'h2222, 8'h55,
                0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd1, 11'd0, 16'h000F, 7'h04};

      cq_tdata = '0; cq_tkeep = 16'h000F; cq_tlast = 1'b0; cq_tuser = '0;
      cq_tvalid = 1'b0; sel = 2'b01; cc_tready = 1'b0;
      m_rdata = '0; m_done = 1'b0;

      repeat (3) tick();
      chk("rst_cq_tready", 32'(cq_tready), 32'd0);
      chk("rst_cc_valid", 32'(cc_tvalid), 32'd0);
      chk("rst_cc_data", 32'(|cc_tdata), 32'd0);
      chk("rst_cc_keep", 32'(cc_tkeep), 32'd0);
      chk("rst_mgmt", 32'({m_rd, m_wr, m_dbg, m_addr, m_be}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("cq_tready_up", 32'(cq_tready), 32'd1);

      for (int i = 0; i < 5; i++) run_vec(vt[i]);

      // Non-config request and wrong select are both swallowed
      send_beat(mk_cq(4'b0000, 8'd0, 10'h004, 16'h0, 8'h01, 32'h0), 4'hF, 1'b1);
      chk("drop_rdy", 32'(cq_tready), 32'd1);
      chk("drop_cc", 32'(cc_tvalid), 32'd0);
      chk("drop_acc", 32'(m_rd | m_wr), 32'd0);
      sel = 2'b10;
      send_beat(mk_cq(4'b1000, 8'd0, 10'h004, 16'h0, 8'h02, 32'h0), 4'hF, 1'b1);
      chk("sel_cc", 32'(cc_tvalid), 32'd0);
      chk("sel_acc", 32'(m_rd | m_wr), 32'd0);
      sel = 2'b01;

      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("idle_done_cc", 32'(cc_tvalid), 32'd0);
      chk("idle_done_rdy", 32'(cq_tready), 32'd1);

      // CC backpressure for five cycles
      send_beat(mk_cq(4'b1000, 8'd0, 10'h004, 16'h0303, 8'h66, 32'h0), 4'hF, 1'b1);
      m_rdata = 32'hCAFEF00D; m_done = 1'b1;
      tick();
      m_done = 1'b0; m_rdata = '0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(cc_tvalid), 32'd1);
         chk("bp_cq_rdy", 32'(cq_tready), 32'd0);
         chk("bp_data", cc_tdata[127:96], 32'hCAFEF00D);
         chk("bp_tag", 32'(cc_tdata[71:64]), 32'h66);
         tick();
      end
      cc_tready = 1'b1;
      tick();
      cc_tready = 1'b0;
      chk("bp_release", 32'(cc_tvalid), 32'd0);
      chk("bp_cq_rdy_after", 32'(cq_tready), 32'd1);

      // Two-beat request is drained without a completion
      send_beat(mk_cq(4'b1000, 8'd0, 10'h004, 16'h0, 8'h77, 32'h0), 4'hF, 1'b0);
      chk("drain_acc", 32'(m_rd | m_wr), 32'd0);
      chk("drain_rdy", 32'(cq_tready), 32'd1);
      send_beat(mk_cq(4'b1000, 8'd0, 10'h004, 16'h0, 8'h78, 32'h0), 4'hF, 1'b1);
      chk("drain_cc", 32'(cc_tvalid), 32'd0);
      chk("drain_acc2", 32'(m_rd | m_wr), 32'd0);
      run_vec(vt[0]);

      // Reset during ACCESS
      send_beat(mk_cq(4'b1000, 8'd0, 10'h004, 16'h0, 8'h79, 32'h0), 4'hF, 1'b1);
      chk("mid_rd", 32'(m_rd), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_mgmt", 32'({m_rd, m_wr, m_addr, m_be}), 32'd0);
      chk("mid_rst_cc", 32'({cc_tvalid, cc_tlast, |cc_tdata}), 32'd0);
      chk("mid_rst_rdy", 32'(cq_tready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mid_rst_idle", 32'(cq_tready), 32'd1);
      chk("mid_rst_nocc", 32'(cc_tvalid), 32'd0);
      run_vec(vt[1]);

`ifdef CQT1_CFG_TIMEOUT_EN
      send_beat(mk_cq(4'b1000, 8'd0, 10'h008, 16'h0404, 8'h88, 32'h0), 4'hF, 1'b1);
      n = 0;
      while (m_rd && n < 40) begin
         n++;
         tick();
      end
      chk("tmo_cycles", 32'(n), 32'd16);
      chk("tmo_valid", 32'(cc_tvalid), 32'd1);
      chk("tmo_st", 32'(cc_tdata[45:43]), 32'd4);
      chk("tmo_dw", 32'(cc_tdata[42:32]), 32'd0);
      chk("tmo_keep", 32'(cc_tkeep), 32'h000F);
      chk("tmo_data", cc_tdata[127:96], 32'd0);
      cc_tready = 1'b1;
      tick();
      cc_tready = 1'b0;
      chk("tmo_done", 32'(cc_tvalid), 32'd0);
`else
      n = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
